// File: rtl/demosaic_pkg.sv
// Shared widths, mode encodings and rounding offsets for the demosaicing
// averaging datapath.
package demosaic_pkg;

  localparam int DATA_W = 5;
  localparam int SUM_W  = 7;

  localparam logic MODE_AVG4 = 1'b0;
  localparam logic MODE_AVG2 = 1'b1;

  // Half an LSB of the divisor, added before the shift to round to nearest
  localparam logic [SUM_W-1:0] RND_AVG4 = 7'd2;
  localparam logic [SUM_W-1:0] RND_AVG2 = 7'd1;

endpackage

// File: rtl/adder4x5.sv
// 4-operand, 5-bit carry-save compressor: two cascaded 3:2 layers, leaving
// a redundant pair whose sum (mod 128) equals a+b+c+d.
module adder4x5
  import demosaic_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [SUM_W-1:0]  out1,
  output logic [SUM_W-1:0]  out2
);

  logic [SUM_W-1:0] a_x, b_x, c_x, d_x;
  logic [SUM_W-1:0] s_l1, c_l1;

  always_comb begin
    a_x  = SUM_W'(a);
    b_x  = SUM_W'(b);
    c_x  = SUM_W'(c);
    d_x  = SUM_W'(d);
    s_l1 = a_x ^ b_x ^ c_x;
    c_l1 = ((a_x & b_x) | (a_x & c_x) | (b_x & c_x)) << 1;
    out1 = s_l1 ^ c_l1 ^ d_x;
    out2 = ((s_l1 & c_l1) | (s_l1 & d_x) | (c_l1 & d_x)) << 1;
  end

endmodule

// File: rtl/csa_share_arbiter.sv
// Round-robin share of one carry-save compressor between two averaging
// requesters, followed by a carry-propagate add and rounded average.
module csa_share_arbiter #(
  parameter int DATA_W = demosaic_pkg::DATA_W,
  parameter int SUM_W  = demosaic_pkg::SUM_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [4*DATA_W-1:0] req0_data,
  input  logic                req0_mode,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [4*DATA_W-1:0] req1_data,
  input  logic                req1_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_id,
  output logic [SUM_W-1:0]    out_sum,
  output logic [DATA_W-1:0]   out_avg,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1,
  output logic                busy
);
  import demosaic_pkg::*;

  logic                last;
  logic                grant0, grant1, acc0, acc1;
  logic                s2_adv, s1_free;
  logic [4*DATA_W-1:0] sel_data;
  logic                sel_mode, sel_id;
  logic [DATA_W-1:0]   op_a, op_b, op_c, op_d;
  logic [SUM_W-1:0]    csa_out1, csa_out2;
  logic                vld_p1, id_p1, mode_p1;
  logic [SUM_W-1:0]    out1_p1, out2_p1;
  logic [SUM_W-1:0]    sum_p2;

  function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] sum,
                                                  input logic mode);
    logic [SUM_W-1:0] t;
    if (mode == MODE_AVG2) begin
      t = sum + RND_AVG2;
      return t[DATA_W:1];
    end
    t = sum + RND_AVG4;
    return t[DATA_W+1:2];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    s2_adv     = !out_valid || out_ready;
    s1_free    = !vld_p1 || s2_adv;
    // last == 1 means port 1 was served most recently, so port 0 wins a tie
    grant0     = req0_valid && (!req1_valid || last);
    grant1     = req1_valid && (!req0_valid || !last);
    req0_ready = grant0 && s1_free;
    req1_ready = grant1 && s1_free;
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    sel_id     = grant1;
    sel_data   = grant1 ? req1_data : req0_data;
    sel_mode   = grant1 ? req1_mode : req0_mode;
    op_a       = sel_data[DATA_W-1:0];
    op_b       = sel_data[2*DATA_W-1:DATA_W];
    op_c       = (sel_mode == MODE_AVG2) ? '0 : sel_data[3*DATA_W-1:2*DATA_W];
    op_d       = (sel_mode == MODE_AVG2) ? '0 : sel_data[4*DATA_W-1:3*DATA_W];
    sum_p2     = out1_p1 + out2_p1;
    busy       = vld_p1 | out_valid;
  end

  adder4x5 u_csa (
    .a    (op_a),
    .b    (op_b),
    .c    (op_c),
    .d    (op_d),
    .out1 (csa_out1),
    .out2 (csa_out2)
  );

  // Stage 1 boundary: carry-save pair captured with its tag and mode
  always_ff @(posedge clk) begin
    if (s1_free && (acc0 || acc1)) begin
      out1_p1 <= csa_out1;
      out2_p1 <= csa_out2;
      id_p1   <= sel_id;
      mode_p1 <= sel_mode;
    end
  end

  // Control, counters and the stage 2 boundary (result registers)
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      if (acc0 || acc1) last <= acc1;
      if (acc0) cnt0 <= sat_inc(cnt0);
      if (acc1) cnt1 <= sat_inc(cnt1);
      if (s1_free) vld_p1 <= acc0 || acc1;
      if (s2_adv) begin
        out_valid <= vld_p1;
        if (vld_p1) begin
          out_sum <= sum_p2;
          out_avg <= round_avg(sum_p2, mode_p1);
          out_id  <= id_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_share_arbiter.sv
// Scoreboard bench for csa_share_arbiter: directed scenarios plus randomized
// streaming with backpressure, checked against an arithmetic reference model.
module tb_csa_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_mode;
  logic        req1_valid, req1_ready, req1_mode;
  logic [19:0] req0_data, req1_data;
  logic        out_valid, out_ready, out_id, busy;
  logic [6:0]  out_sum;
  logic [4:0]  out_avg;
  logic [15:0] cnt0, cnt1;

  logic        s_req0_valid, s_req0_ready, s_req1_ready;
  logic        s_out_valid, s_out_id, s_busy;
  logic [6:0]  s_out_sum;
  logic [4:0]  s_out_avg;
  logic [1:0]  s_cnt0, s_cnt1;

  always #5 clk = ~clk;

  csa_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_sum(out_sum), .out_avg(out_avg), .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  csa_share_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_data(20'h00421), .req0_mode(1'b0),
    .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_data(20'h0), .req1_mode(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_id(s_out_id),
    .out_sum(s_out_sum), .out_avg(s_out_avg), .cnt0(s_cnt0), .cnt1(s_cnt1), .busy(s_busy)
  );

  typedef struct {
    logic id;
    int   sum;
    int   avg;
  } exp_t;

  exp_t exp_q[$];
  int   ids_q[$];
  int   cyc_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic collect = 1'b0;
  logic last_m = 1'b1;
  logic acc0_q = 1'b0;
  logic acc1_q = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [19:0] d, input logic mode);
    exp_t e;
    int a, b, c, dd;
    a  = int'(d[4:0]);
    b  = int'(d[9:5]);
    c  = int'(d[14:10]);
    dd = int'(d[19:15]);
    e.id = id;
    if (mode) begin
      e.sum = a + b;
      e.avg = (e.sum + 1) / 2;
    end else begin
      e.sum = a + b + c + dd;
      e.avg = (e.sum + 2) / 4;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side: record accepted groups and check round-robin fairness
  always @(negedge clk) begin
    acc0_q = 1'b0;
    acc1_q = 1'b0;
    if (rst) begin
      exp_q.delete();
      last_m = 1'b1;
    end else begin
      check("ready_exclusive", int'(req0_ready & req1_ready), 0);
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        check("rr_grant0", int'(req0_ready), int'(last_m));
      if (req0_valid && req0_ready) begin
        exp_q.push_back(model(1'b0, req0_data, req0_mode));
        last_m = 1'b0;
        acc0_q = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(model(1'b1, req1_data, req1_mode));
        last_m = 1'b1;
        acc1_q = 1'b1;
      end
    end
  end

  // Monitor: pop and compare each delivered result; outputs frozen while stalled
  logic       stall_prev = 1'b0;
  logic [6:0] ps;
  logic [4:0] pa;
  logic       pi;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_sum", int'(out_sum), int'(ps));
        check("stall_avg", int'(out_avg), int'(pa));
        check("stall_id", int'(out_id), int'(pi));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=sum%0d required=none", out_sum);
        end else begin
          e = exp_q.pop_front();
          check("out_id", int'(out_id), int'(e.id));
          check("out_sum", int'(out_sum), e.sum);
          check("out_avg", int'(out_avg), e.avg);
          if (collect) begin
            ids_q.push_back(int'(out_id));
            cyc_q.push_back(cyc);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      ps = out_sum;
      pa = out_avg;
      pi = out_id;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_mode = 1'b0;
  endtask

  task automatic refresh(input int pct);
    if (!req0_valid || acc0_q) begin
      req0_valid = ($urandom_range(99) < pct);
      req0_data  = 20'($urandom);
      req0_mode  = 1'($urandom_range(1));
    end
    if (!req1_valid || acc1_q) begin
      req1_valid = ($urandom_range(99) < pct);
      req1_data  = 20'($urandom);
      req1_mode  = 1'($urandom_range(1));
    end
  endtask

  task automatic send(input logic port, input logic [19:0] d, input logic m);
    int n = 0;
    if (port) begin req1_valid = 1'b1; req1_data = d; req1_mode = m; end
    else      begin req0_valid = 1'b1; req0_data = d; req0_mode = m; end
    do begin
      step();
      n++;
    end while (!(port ? acc1_q : acc0_q) && n < 50);
    check("send_accept", int'(port ? acc1_q : acc0_q), 1);
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    out_ready = 1'b1;
    s_req0_valid = 1'b0;
    idle_inputs();
    step(); step(); step();
    rst = 1'b0;

    // Reset state and first-cycle acceptance of port 0, then pipeline latency
    req0_valid = 1'b1; req0_data = {5'd31, 5'd31, 5'd31, 5'd31}; req0_mode = 1'b0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt0", int'(cnt0), 0);
    check("rst_cnt1", int'(cnt1), 0);
    check("first_ready0", int'(req0_ready), 1);
    step();
    check("first_accept", int'(acc0_q), 1);
    req0_valid = 1'b0;
    #2;
    check("lat_s1_out_valid", int'(out_valid), 0);
    check("lat_s1_busy", int'(busy), 1);
    step();
    #2;
    check("lat_s2_out_valid", int'(out_valid), 1);
    check("basic_cnt0", int'(cnt0), 1);
    step();

    // AVG2 with ignored C/D, then small AVG4 rounding case
    send(1'b1, {5'd31, 5'd31, 5'd4, 5'd3}, 1'b1);
    send(1'b0, {5'd0, 5'd0, 5'd1, 5'd1}, 1'b0);
    drain();

    // Contention: both ports valid for six cycles
    do_reset();
    collect = 1'b1;
    req0_valid = 1'b1; req0_data = 20'($urandom); req0_mode = 1'($urandom_range(1));
    req1_valid = 1'b1; req1_data = 20'($urandom); req1_mode = 1'($urandom_range(1));
    for (int i = 0; i < 6; i++) begin
      step();
      refresh(100);
    end
    idle_inputs();
    drain();
    collect = 1'b0;
    check("cont_count", ids_q.size(), 6);
    for (int i = 0; i < ids_q.size() && i < 6; i++) begin
      check("cont_id", ids_q[i], i % 2);
      if (i > 0) check("cont_gap", cyc_q[i] - cyc_q[i-1], 1);
    end
    check("cont_cnt0", int'(cnt0), 3);
    check("cont_cnt1", int'(cnt1), 3);

    // Backpressure while streaming with both stages full
    refresh(100);
    for (int i = 0; i < 5; i++) begin
      step();
      refresh(100);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp_ready0", int'(req0_ready), 0);
      check("bp_ready1", int'(req1_ready), 0);
      step();
      refresh(100);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      refresh(70);
      out_ready = ($urandom_range(99) < 60);
    end
    idle_inputs();
    drain();

    // Reset pulse with both stages full
    refresh(100);
    for (int i = 0; i < 4; i++) begin
      step();
      refresh(100);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_cnt0", int'(cnt0), 0);
    check("mrst_cnt1", int'(cnt1), 0);
    check("mrst_ready0", int'(req0_ready), 1);
    check("mrst_ready1", int'(req1_ready), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      refresh(100);
    end
    idle_inputs();
    drain();

    // Saturation on the 2-bit-counter instance
    s_req0_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      #2;
      if (s_req0_ready) k++;
      step();
    end
    s_req0_valid = 1'b0;
    check("sat_transfers", k, 5);
    #2;
    check("sat_cnt0", int'(s_cnt0), 3);
    check("sat_cnt1", int'(s_cnt1), 0);
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
